// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM duty ramp
// State and mode encodings plus the perceptual table used when GAMMA_LUT_EN is defined.
package pwm_pkg;

  localparam int DUTY_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UP       = 3'd1,
    HOLD_TOP = 3'd2,
    DOWN     = 3'd3,
    HOLD_BOT = 3'd4
  } state_t;

  localparam logic [1:0] MODE_OFF    = 2'b00;
  localparam logic [1:0] MODE_TRI    = 2'b01;
  localparam logic [1:0] MODE_SAW    = 2'b10;
  localparam logic [1:0] MODE_STATIC = 2'b11;

  // Entry 15 first; monotonic with gamma(0)=0 and gamma(15)=15.
  localparam logic [15:0][DUTY_W-1:0] GAMMA_TABLE = {
    4'd15, 4'd13, 4'd11, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4,
    4'd3,  4'd2,  4'd2,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0
  };

endpackage

// File: rtl/pwm_gamma_lut.sv
// rtl/pwm_gamma_lut.sv - combinational level to perceptual duty map
// Only instantiated when GAMMA_LUT_EN is defined.
module pwm_gamma_lut
  import pwm_pkg::*;
(
  input  logic [DUTY_W-1:0] level,
  output logic [DUTY_W-1:0] duty
);

  assign duty = GAMMA_TABLE[level];

endmodule

// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - triangle/sawtooth/static duty generator for a 4-bit PWM stage
// Define GAMMA_LUT_EN to map level through the perceptual table; otherwise duty is linear.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int PERIOD_CYCLES = 16,
  parameter int STEP_DIV      = 4,
  parameter int HOLD_STEPS    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DUTY_W-1:0] static_level,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_upd,
  output logic              at_peak,
  output logic              at_floor
);

  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  logic [PW-1:0]     pcnt;
  logic [SW-1:0]     scnt, scnt_nxt;
  logic [HW-1:0]     hcnt, hcnt_nxt;
  logic [DUTY_W-1:0] level, level_nxt, duty_nxt;
  logic [1:0]        mode_q;
  state_t            state, state_nxt;
  logic              pbound, step;

  assign pbound   = en && (pcnt == PW'(PERIOD_CYCLES - 1));
  assign step     = pbound && (scnt == SW'(STEP_DIV - 1));
  assign at_peak  = (state == HOLD_TOP);
  assign at_floor = (state == HOLD_BOT);

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    hcnt_nxt  = hcnt;
    scnt_nxt  = scnt;
    if (pbound) begin
      scnt_nxt = (scnt == SW'(STEP_DIV - 1)) ? '0 : scnt + SW'(1);
      // Mode handling wins over a step landing on the same boundary.
      if (mode == MODE_OFF) begin
        state_nxt = IDLE;
        level_nxt = '0;
      end else if (mode == MODE_STATIC) begin
        state_nxt = IDLE;
        level_nxt = static_level;
      end else if (state == IDLE) begin
        state_nxt = UP;
        level_nxt = '0;
        scnt_nxt  = '0;
      end else if (mode != mode_q) begin
        state_nxt = UP;
      end else if (step) begin
        case (state)
          UP: begin
            if (mode == MODE_SAW) begin
              level_nxt = level + 4'd1;
            end else if (level != 4'd15) begin
              level_nxt = level + 4'd1;
            end else begin
              state_nxt = HOLD_TOP;
              hcnt_nxt  = '0;
            end
          end
          HOLD_TOP: begin
            if (hcnt == HW'(HOLD_STEPS - 1)) state_nxt = DOWN;
            else hcnt_nxt = hcnt + HW'(1);
          end
          DOWN: begin
            if (level != 4'd0) begin
              level_nxt = level - 4'd1;
            end else begin
              state_nxt = HOLD_BOT;
              hcnt_nxt  = '0;
            end
          end
          HOLD_BOT: begin
            if (hcnt == HW'(HOLD_STEPS - 1)) state_nxt = UP;
            else hcnt_nxt = hcnt + HW'(1);
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

`ifdef GAMMA_LUT_EN
  pwm_gamma_lut u_gamma (
    .level (level_nxt),
    .duty  (duty_nxt)
  );
`else
  assign duty_nxt = level_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt     <= '0;
      scnt     <= '0;
      hcnt     <= '0;
      level    <= '0;
      state    <= IDLE;
      mode_q   <= MODE_OFF;
      duty     <= '0;
      duty_upd <= 1'b0;
    end else begin
      if (en) pcnt <= (pcnt == PW'(PERIOD_CYCLES - 1)) ? '0 : pcnt + PW'(1);
      scnt  <= scnt_nxt;
      hcnt  <= hcnt_nxt;
      level <= level_nxt;
      state <= state_nxt;
      // duty shares the level's boundary edge so the PWM sees it at the next period start.
      if (pbound) begin
        mode_q <= mode;
        duty   <= duty_nxt;
      end
      duty_upd <= pbound && (duty_nxt != duty);
    end
  end

endmodule
